// File: rtl/cpu_sel_pkg.sv
// Shared sizing constants for the Mini SRC register select stage.
// Field positions follow the Mini SRC instruction format.
package cpu_sel_pkg;

    localparam int NREGS  = 16;
    localparam int IDX_W  = $clog2(NREGS);
    localparam int IR_W   = 32;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;
    localparam int C_W    = 19;

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with an enable; output is all zeros when disabled.
module onehot_decoder #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_select_unit.sv
// Clocked register select stage: IR latch, one-hot Rin/Rout enables,
// write-pending scoreboard with hazard flag, and R0-as-zero base reads.
module reg_select_unit #(
    parameter int NREGS   = cpu_sel_pkg::NREGS,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int IR_W    = cpu_sel_pkg::IR_W,
    parameter int RA_LSB  = cpu_sel_pkg::RA_LSB,
    parameter int RB_LSB  = cpu_sel_pkg::RB_LSB,
    parameter int RC_LSB  = cpu_sel_pkg::RC_LSB,
    parameter int C_W     = cpu_sel_pkg::C_W,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [IR_W-1:0]  IR_in,
    input  logic             IRload,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic             e_Rin,
    input  logic             e_Rout,
    input  logic             BAout,
    input  logic             mark_pend,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             BA_zero,
    output logic [31:0]      C_sign_ext,
    output logic [IDX_W-1:0] sel_idx,
    output logic [NREGS-1:0] pend,
    output logic             hazard,
    output logic             sel_err
);

    logic [IR_W-1:0]  ir_q, ir_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic             sel_err_q, sel_err_d;
    logic             readReq;
    logic             routEn;
    logic             multiSel;
    logic [NREGS-1:0] markVec;

    // Field decode always works from the latched IR, never from the bus.
    always_comb begin
        sel_idx = '0;
        if (Gra) begin
            sel_idx = ir_q[RA_LSB +: IDX_W];
        end else if (Grb) begin
            sel_idx = ir_q[RB_LSB +: IDX_W];
        end else if (Grc) begin
            sel_idx = ir_q[RC_LSB +: IDX_W];
        end
    end

    always_comb begin
        C_sign_ext = '0;
        for (int i = 0; i < 32; i++) begin
            C_sign_ext[i] = (i < C_W) ? ir_q[i] : ir_q[C_W-1];
        end
    end

    // A base-address read of R0 is served by the bus mux driving zero,
    // so the register file must not also be read.
    assign readReq = e_Rout | BAout;
    assign BA_zero = R0_ZERO && BAout && (sel_idx == '0);
    assign routEn  = readReq && !BA_zero;
    assign hazard  = routEn && pend_q[sel_idx];

    onehot_decoder #(.N(NREGS), .IDX_W(IDX_W)) u_rin_dec (
        .idx    (sel_idx),
        .en     (e_Rin),
        .onehot (Rin)
    );

    onehot_decoder #(.N(NREGS), .IDX_W(IDX_W)) u_rout_dec (
        .idx    (sel_idx),
        .en     (routEn),
        .onehot (Rout)
    );

    assign multiSel = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);

    // A register written and marked in the same cycle stays pending.
    always_comb begin
        markVec = '0;
        if (mark_pend) begin
            markVec[sel_idx] = 1'b1;
        end
        pend_d = (pend_q & ~Rin) | markVec;
        ir_d   = IRload ? IR_in : ir_q;
        sel_err_d = sel_err_q;
        if (multiSel) begin
            sel_err_d = 1'b1;
        end else if (IRload) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            ir_q      <= '0;
            pend_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            pend_q    <= pend_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign pend    = pend_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_select_unit.sv
// Self-checking bench for reg_select_unit: directed steps followed by
// randomized traffic, all checked against a behavioural model.
module tb_reg_select_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR_in;
    logic        IRload;
    logic        Gra, Grb, Grc;
    logic        e_Rin, e_Rout, BAout, mark_pend;
    logic [15:0] Rin, Rout, pend;
    logic        BA_zero, hazard, sel_err;
    logic [31:0] C_sign_ext;
    logic [3:0]  sel_idx;

    int checks = 0;
    int passes = 0;

    // Reference state kept at the level of the instruction word and a
    // per-register pending flag.
    logic [31:0] mIr;
    bit          mPend [16];
    bit          mErr;

    reg_select_unit dut (
        .clock      (clock),
        .clear      (clear),
        .IR_in      (IR_in),
        .IRload     (IRload),
        .Gra        (Gra),
        .Grb        (Grb),
        .Grc        (Grc),
        .e_Rin      (e_Rin),
        .e_Rout     (e_Rout),
        .BAout      (BAout),
        .mark_pend  (mark_pend),
        .Rin        (Rin),
        .Rout       (Rout),
        .BA_zero    (BA_zero),
        .C_sign_ext (C_sign_ext),
        .sel_idx    (sel_idx),
        .pend       (pend),
        .hazard     (hazard),
        .sel_err    (sel_err)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic int fieldOf(input logic [31:0] ir, input int lsb);
        return (int'(ir) >>> lsb) & 15;
    endfunction

    function automatic int modelSel();
        if (Gra) return fieldOf(mIr, 23);
        if (Grb) return fieldOf(mIr, 19);
        if (Grc) return fieldOf(mIr, 15);
        return 0;
    endfunction

    function automatic logic [15:0] pendWord();
        logic [15:0] w = '0;
        for (int r = 0; r < 16; r++) if (mPend[r]) w = w + 16'(1 << r);
        return w;
    endfunction

    function automatic logic [31:0] modelConst();
        longint c = longint'(mIr % (1 << 19));
        if (c >= (1 << 18)) c = c - (1 << 19);
        return 32'(c);
    endfunction

    task automatic checkOutput(input string tag);
        int  s;
        bit  baz, rd;
        s   = modelSel();
        baz = BAout && (s == 0);
        rd  = (e_Rout || BAout) && !baz;
        cmp({tag, "_sel"},    32'(sel_idx), 32'(s));
        cmp({tag, "_rin"},    32'(Rin),     e_Rin ? 32'(1 << s) : 32'd0);
        cmp({tag, "_rout"},   32'(Rout),    rd ? 32'(1 << s) : 32'd0);
        cmp({tag, "_bazero"}, 32'(BA_zero), 32'(baz));
        cmp({tag, "_const"},  C_sign_ext,   modelConst());
        cmp({tag, "_hazard"}, 32'(hazard),  32'(rd && mPend[s]));
        cmp({tag, "_pend"},   32'(pend),    32'(pendWord()));
        cmp({tag, "_selerr"}, 32'(sel_err), 32'(mErr));
    endtask

    // Advances one clock and applies the architectural rules to the model.
    task automatic tick();
        int s;
        int nsel;
        s    = modelSel();
        nsel = int'(Gra) + int'(Grb) + int'(Grc);
        @(posedge clock);
        if (clear) begin
            mIr = '0;
            mErr = 0;
            for (int r = 0; r < 16; r++) mPend[r] = 0;
        end else begin
            if (e_Rin) mPend[s] = 0;
            if (mark_pend) mPend[s] = 1;
            if (nsel >= 2) mErr = 1;
            else if (IRload) mErr = 0;
            if (IRload) mIr = IR_in;
        end
        @(negedge clock);
    endtask

    task automatic applyStimulus(input bit a, input bit b, input bit c, input bit wr,
                                 input bit rd, input bit ba, input bit mk);
        Gra = a; Grb = b; Grc = c;
        e_Rin = wr; e_Rout = rd; BAout = ba; mark_pend = mk;
        #1;
    endtask

    task automatic loadIr(input logic [31:0] v);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        IR_in = v; IRload = 1;
        tick();
        IRload = 0;
    endtask

    initial begin
        clear = 1; IRload = 0; IR_in = 32'hFFFF_FFFF;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        tick();
        clear = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset");
        cmp("reset_c_zero", C_sign_ext, 32'h0);
        tick();

        loadIr(32'h029C_8000);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("ra_rin");
        cmp("ra_rin_lit", 32'(Rin), 32'h0020);
        cmp("const_lit", C_sign_ext, 32'hFFFC_8000);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        checkOutput("rb_rout");
        cmp("rb_rout_lit", 32'(Rout), 32'h0008);
        tick();
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checkOutput("rc_rout");
        cmp("rc_rout_lit", 32'(Rout), 32'h0200);
        tick();

        applyStimulus(1, 0, 1, 1, 0, 0, 0);
        checkOutput("prio");
        cmp("prio_lit", 32'(Rin), 32'h0020);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cmp("selerr_set", 32'(sel_err), 32'd1);
        loadIr(32'h0280_0000);
        cmp("selerr_clr", 32'(sel_err), 32'd0);

        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        checkOutput("r0_ba");
        cmp("r0_ba_lit", {15'd0, BA_zero, Rout}, 32'h0001_0000);
        tick();
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        checkOutput("r0_rout");
        cmp("r0_rout_lit", {15'd0, BA_zero, Rout}, 32'h0000_0001);
        tick();

        loadIr(32'h029C_8000);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("sb_mark");
        cmp("sb_pend_lit", 32'(pend), 32'h0020);
        cmp("sb_hazard_lit", 32'(hazard), 32'd1);
        tick();
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("sb_write");
        cmp("sb_clr_lit", {15'd0, hazard, pend}, 32'h0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_both");
        cmp("sb_both_lit", 32'(pend), 32'h0020);

        IR_in = 32'h0380_0000; IRload = 1;
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("ldcyc");
        cmp("ldcyc_lit", 32'(Rin), 32'h0020);
        tick();
        IRload = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        cmp("ldcyc_new", 32'(sel_idx), 32'd7);

        for (int r = 0; r < 16; r++) begin
            loadIr(32'(r) << 23);
            applyStimulus(1, 0, 0, 0, 0, 0, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cmp("pend_full", 32'(pend), 32'h0000_FFFF);
        clear = 1; IRload = 1; IR_in = 32'h1234_5678;
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        tick();
        clear = 0; IRload = 0;
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("midclr");
        cmp("midclr_lit", {C_sign_ext[15:0], pend}, 32'h0);

        for (int n = 0; n < 400; n++) begin
            clear  = ($urandom_range(0, 39) == 0);
            IRload = ($urandom_range(0, 3) == 0);
            IR_in  = $urandom;
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                          1'($urandom));
            checkOutput("rand");
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
